// File: rtl/trace_commit_scheduler.sv
// Orders dual-slot writeback commits into a single trace stream through a circular queue
// and a valid/ready output register, with registered stall request and sticky overflow.
module trace_commit_scheduler #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AW           = 4,
    parameter int unsigned STALL_THRESH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          cmt_valid_0,
    input  logic          cmt_valid_1,
    input  logic [31:0]   cmt_pc_0,
    input  logic [31:0]   cmt_pc_1,
    input  logic [4:0]    cmt_wnum_0,
    input  logic [4:0]    cmt_wnum_1,
    input  logic [31:0]   cmt_wdata_0,
    input  logic [31:0]   cmt_wdata_1,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [31:0]   trace_pc,
    output logic [31:0]   trace_wdata,
    output logic [4:0]    trace_wnum,
    output logic [3:0]    trace_wen,
    output logic          stall_req,
    output logic          overflow,
    output logic [AW:0]   occupancy
);

    typedef enum logic [1:0] {StEmpty, StActive, StBp, StOvf} state_e;

    state_e        state, state_next;
    logic [68:0]   ram [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic [1:0]    n_in, n_acc;
    logic          pop, ovf_event, trace_valid_next;
    logic [AW+1:0] free_now, free_next;

    always_comb begin
        n_in      = {1'b0, cmt_valid_0} + {1'b0, cmt_valid_1};
        pop       = (count != '0) && (!trace_valid || trace_ready);
        // A same-cycle pop frees a slot for this cycle's commits.
        free_now  = (AW+2)'(DEPTH) - {1'b0, count} + {{(AW+1){1'b0}}, pop};
        ovf_event = (state != StOvf) && ({{AW{1'b0}}, n_in} > free_now);
        n_acc     = (state == StOvf || ovf_event) ? 2'd0 : n_in;
        count_next = count + {{(AW-1){1'b0}}, n_acc} - {{AW{1'b0}}, pop};
        free_next  = (AW+2)'(DEPTH) - {1'b0, count_next};
        trace_valid_next = pop | (trace_valid & ~trace_ready);

        if (state == StOvf || ovf_event) begin
            state_next = StOvf;
        end else if (free_next <= (AW+2)'(STALL_THRESH)) begin
            state_next = StBp;
        end else if (count_next == '0 && !trace_valid_next) begin
            state_next = StEmpty;
        end else begin
            state_next = StActive;
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!flush && n_acc != 2'd0) begin
            if (cmt_valid_0) begin
                ram[wr_ptr] <= {cmt_pc_0, cmt_wdata_0, cmt_wnum_0};
            end
            if (cmt_valid_1) begin
                ram[cmt_valid_0 ? wr_ptr + AW'(1) : wr_ptr] <= {cmt_pc_1, cmt_wdata_1, cmt_wnum_1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StEmpty;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            stall_req   <= 1'b0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_wdata <= '0;
            trace_wnum  <= '0;
        end else if (flush) begin
            state       <= StEmpty;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            stall_req   <= 1'b0;
            trace_valid <= 1'b0;
        end else begin
            state       <= state_next;
            wr_ptr      <= wr_ptr + AW'(n_acc);
            count       <= count_next;
            stall_req   <= (state_next == StBp) || (state_next == StOvf);
            trace_valid <= trace_valid_next;
            if (ovf_event) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                {trace_pc, trace_wdata, trace_wnum} <= ram[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign trace_wen = {4{trace_valid}};
    assign occupancy = count;

endmodule

// File: tb/tb_trace_commit_scheduler.sv
// Scoreboard bench for trace_commit_scheduler: directed commits push expected entries,
// a forked monitor pops and compares on every output handshake.
module tb_trace_commit_scheduler;

    localparam int unsigned DEPTH        = 16;
    localparam int unsigned AW           = 4;
    localparam int unsigned STALL_THRESH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [4:0]  wnum;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        cmt_valid_0 = 1'b0, cmt_valid_1 = 1'b0;
    logic [31:0] cmt_pc_0 = '0, cmt_pc_1 = '0;
    logic [4:0]  cmt_wnum_0 = '0, cmt_wnum_1 = '0;
    logic [31:0] cmt_wdata_0 = '0, cmt_wdata_1 = '0;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [31:0] trace_pc, trace_wdata;
    logic [4:0]  trace_wnum;
    logic [3:0]  trace_wen;
    logic        stall_req, overflow;
    logic [AW:0] occupancy;

    ent_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    trace_commit_scheduler #(
        .DEPTH(DEPTH),
        .AW(AW),
        .STALL_THRESH(STALL_THRESH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .cmt_valid_0(cmt_valid_0),
        .cmt_valid_1(cmt_valid_1),
        .cmt_pc_0(cmt_pc_0),
        .cmt_pc_1(cmt_pc_1),
        .cmt_wnum_0(cmt_wnum_0),
        .cmt_wnum_1(cmt_wnum_1),
        .cmt_wdata_0(cmt_wdata_0),
        .cmt_wdata_1(cmt_wdata_1),
        .trace_valid(trace_valid),
        .trace_ready(trace_ready),
        .trace_pc(trace_pc),
        .trace_wdata(trace_wdata),
        .trace_wnum(trace_wnum),
        .trace_wen(trace_wen),
        .stall_req(stall_req),
        .overflow(overflow),
        .occupancy(occupancy)
    );

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc    = pc;
        e.wdata = pc ^ 32'h5A5A_C3C3;
        e.wnum  = pc[6:2];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic commit(input logic v0, input logic v1, input ent_t e0, input ent_t e1,
                          input bit expect_ok);
        cmt_valid_0 = v0;
        cmt_valid_1 = v1;
        cmt_pc_0 = e0.pc;  cmt_wdata_0 = e0.wdata;  cmt_wnum_0 = e0.wnum;
        cmt_pc_1 = e1.pc;  cmt_wdata_1 = e1.wdata;  cmt_wnum_1 = e1.wnum;
        if (expect_ok) begin
            if (v0) exp_q.push_back(e0);
            if (v1) exp_q.push_back(e1);
        end
        tick();
        cmt_valid_0 = 1'b0;
        cmt_valid_1 = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        trace_ready = 1'b1;
        while ((exp_q.size() != 0 || trace_valid) && n < limit) begin
            tick();
            n++;
        end
        chk("drain_in_time", 32'(n < limit), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(trace_valid), 32'd0);
        chk({tag, "_wen"},   32'(trace_wen), 32'h0);
        chk({tag, "_pc"},    trace_pc, 32'h0);
        chk({tag, "_stall"}, 32'(stall_req), 32'd0);
        chk({tag, "_ovf"},   32'(overflow), 32'd0);
        chk({tag, "_occ"},   32'(occupancy), 32'd0);
    endtask

    initial begin
        int exp_occ[7];
        exp_occ = '{2, 3, 5, 7, 9, 11, 13};

        fork
            begin : monitor
                ent_t e;
                forever begin
                    @(negedge clk);
                    if (reset && !flush && trace_valid && trace_ready) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL trace_unexpected: got pc=%h want no entry", trace_pc);
                        end else begin
                            e = exp_q.pop_front();
                            if ({trace_pc, trace_wdata, trace_wnum} !== e || trace_wen !== 4'hF) begin
                                bad++;
                                $display("FAIL trace_entry: got pc=%h wdata=%h wnum=%0d wen=%h want pc=%h wdata=%h wnum=%0d wen=f",
                                         trace_pc, trace_wdata, trace_wnum, trace_wen,
                                         e.pc, e.wdata, e.wnum);
                            end
                        end
                    end
                end
            end
            begin : watchdog
                #400000;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk_reset_outputs("rst");
        reset = 1'b1;
        tick();

        // Single commit: visible after the second edge, for exactly one cycle
        trace_ready = 1'b1;
        commit(1'b1, 1'b0, '{32'hBFC0_0000, 32'h1234_5678, 5'd3}, mk(32'h0), 1'b1);
        chk("single_e0_valid", 32'(trace_valid), 32'd0);
        chk("single_e0_occ", 32'(occupancy), 32'd1);
        tick();
        chk("single_e1_valid", 32'(trace_valid), 32'd1);
        chk("single_e1_wen", 32'(trace_wen), 32'hF);
        chk("single_e1_pc", trace_pc, 32'hBFC0_0000);
        tick();
        chk("single_e2_valid", 32'(trace_valid), 32'd0);

        // Dual commit ordering
        commit(1'b1, 1'b1, mk(32'h100), mk(32'h104), 1'b1);
        tick();
        chk("dual_e1_pc", trace_pc, 32'h100);
        chk("dual_e1_occ", 32'(occupancy), 32'd1);
        tick();
        chk("dual_e2_pc", trace_pc, 32'h104);
        chk("dual_e2_occ", 32'(occupancy), 32'd0);
        tick();
        chk("dual_e3_valid", 32'(trace_valid), 32'd0);

        // Backpressure: dual commits with ready low until stall
        trace_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            commit(1'b1, 1'b1, mk(32'h1000 + 32'(8 * i)), mk(32'h1004 + 32'(8 * i)), 1'b1);
            chk("bp_occ", 32'(occupancy), 32'(exp_occ[i]));
            chk("bp_stall", 32'(stall_req), 32'(i == 6));
        end
        chk("bp_no_ovf", 32'(overflow), 32'd0);
        trace_ready = 1'b1;
        tick();
        chk("bp_rel1_occ", 32'(occupancy), 32'd12);
        chk("bp_rel1_stall", 32'(stall_req), 32'd1);
        tick();
        chk("bp_rel2_occ", 32'(occupancy), 32'd11);
        chk("bp_rel2_stall", 32'(stall_req), 32'd0);
        drain(40);
        chk("bp_end_ovf", 32'(overflow), 32'd0);

        // Forced overflow: ninth dual commit does not fit
        trace_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            commit(1'b1, 1'b1, mk(32'h2000 + 32'(8 * i)), mk(32'h2004 + 32'(8 * i)), i < 8);
            chk("ovf_flag", 32'(overflow), 32'(i == 8));
        end
        chk("ovf_occ", 32'(occupancy), 32'd15);
        chk("ovf_stall", 32'(stall_req), 32'd1);
        commit(1'b1, 1'b1, mk(32'h2100), mk(32'h2104), 1'b0);
        chk("ovf_ignored_occ", 32'(occupancy), 32'd15);
        drain(40);
        chk("ovf_drained_stall", 32'(stall_req), 32'd1);
        chk("ovf_drained_flag", 32'(overflow), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("ovf_flush_stall", 32'(stall_req), 32'd0);
        chk("ovf_flush_flag", 32'(overflow), 32'd0);

        // Flush mid-stream with a dual commit in the flush cycle
        trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            commit(1'b1, 1'b1, mk(32'h3000 + 32'(8 * i)), mk(32'h3004 + 32'(8 * i)), 1'b1);
        end
        chk("fl_pre_occ", 32'(occupancy), 32'd7);
        chk("fl_pre_valid", 32'(trace_valid), 32'd1);
        exp_q.delete();
        flush = 1'b1;
        commit(1'b1, 1'b1, mk(32'h3F00), mk(32'h3F04), 1'b0);
        flush = 1'b0;
        chk("fl_valid", 32'(trace_valid), 32'd0);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_ovf", 32'(overflow), 32'd0);
        chk("fl_stall", 32'(stall_req), 32'd0);
        trace_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("fl_quiet", 32'(trace_valid), 32'd0);
        end

        // Mixed commits with random ready, honouring stall, across pointer wrap
        for (int i = 0; i < 40; i++) begin
            int n = 0;
            int pat = i % 3;
            trace_ready = 1'($urandom_range(0, 1));
            while (stall_req && n < 100) begin
                tick();
                trace_ready = 1'($urandom_range(0, 1));
                n++;
            end
            if (n >= 100) chk("wrap_stall_timeout", 32'(stall_req), 32'd0);
            commit(pat != 1, pat != 0, mk(32'h4000 + 32'(8 * i)), mk(32'h4004 + 32'(8 * i)), 1'b1);
        end
        drain(200);
        chk("wrap_no_ovf", 32'(overflow), 32'd0);

        // Asynchronous reset mid-drain
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            commit(1'b1, 1'b1, mk(32'h5000 + 32'(8 * i)), mk(32'h5004 + 32'(8 * i)), 1'b1);
        end
        chk("ar_pre_valid", 32'(trace_valid), 32'd1);
        #3;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("ar");
        #2;
        reset = 1'b1;
        tick();
        chk("ar_post_valid", 32'(trace_valid), 32'd0);
        chk("ar_post_occ", 32'(occupancy), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_commit_scheduler.md
# trace_commit_scheduler

Schedules the dual-issue core's register-writeback commits into a single ordered trace stream for the debug/trace comparator. Up to two commits per cycle (slot 0 older than slot 1) are queued in a circular buffer and drained one per cycle through a valid/ready output register. The block raises a stall request to the commit stage before the buffer can overflow. It sits between the writeback stage and the off-core trace checker, and replaces free-running FIFO writes with flow-controlled, lossless sequencing.

## Interface
- DEPTH, 16, queue entries; power of two, ≥ 8
- AW, 4, log2(DEPTH)
- STALL_THRESH, 4, stall_req asserted when free entries ≤ STALL_THRESH; must be ≥ 2
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- flush  in  1  synchronous clear of queue, output register and overflow flag
- cmt_valid_0 / cmt_valid_1  in  1  slot commits a register write this cycle
- cmt_pc_0 / cmt_pc_1  in  32  commit PC
- cmt_wnum_0 / cmt_wnum_1  in  5  destination register number
- cmt_wdata_0 / cmt_wdata_1  in  32  writeback data
- trace_valid  out  1  trace_* holds a valid entry
- trace_ready  in  1  consumer accepts the entry this cycle
- trace_pc  out  32  entry PC
- trace_wdata  out  32  entry data
- trace_wnum  out  5  entry register number
- trace_wen  out  4  4'hF when trace_valid, else 4'h0
- stall_req  out  1  commit stage must not present commits in the following cycle
- overflow  out  1  sticky; commits were dropped
- occupancy  out  AW+1  queue entries, excluding the output register

## Operation
- Queue: DEPTH x 69-bit entries {pc, wdata, wnum}, with wr_ptr/rd_ptr (AW bits, natural wrap) and count (AW+1 bits).
- Enqueue: n_in = cmt_valid_0 + cmt_valid_1. Slot 0 is written at wr_ptr, slot 1 at wr_ptr+1 (mod DEPTH). If only slot 1 is valid, it is written at wr_ptr. wr_ptr advances by n_in.
- Pop: when count > 0 and (!trace_valid or trace_ready), the output register loads ram[rd_ptr] and rd_ptr advances by 1. When trace_valid & trace_ready and count == 0, trace_valid clears. Output fields hold their value while trace_valid & !trace_ready.
- count_next = count + n_in − pop. The free check uses pre-update count plus pop, so a same-cycle pop frees one slot for the incoming commits.
- Overflow: if n_in > DEPTH − count + pop, both incoming entries are dropped (never a partial write), overflow is set, and the FSM enters OVF.
- FSM (registered):
  - EMPTY: count == 0 and !trace_valid.
  - ACTIVE: data present, free > STALL_THRESH.
  - BP: free ≤ STALL_THRESH.
  - OVF: sticky.
  - Transitions are evaluated on count_next: EMPTY↔ACTIVE↔BP per the thresholds, and any state → OVF on an overflow event.
- OVF: all commits are ignored, draining continues, stall_req = 1. OVF is left only by flush or reset.
- stall_req = (state == BP) | (state == OVF). Because it is registered, the core sees it one cycle late. STALL_THRESH ≥ 2 guarantees no loss on a single late cycle of dual commits.
- flush: ptrs, count and overflow are cleared, trace_valid ← 0, state ← EMPTY. Commits in the flush cycle are dropped and the pop is suppressed. flush has priority over all other events.

## Timing
- Reset values: trace_valid 0, trace_pc/wdata/wnum 0, trace_wen 4'h0, stall_req 0, overflow 0, occupancy 0, state EMPTY. Reset is asynchronous assert with synchronous-safe deassert, provided externally.
- Latency: a commit sampled at edge E appears on trace_* after edge E+1 when the queue and output are empty. A slot-1 commit in the same cycle appears one cycle after slot 0.
- Throughput: 1 entry/cycle out; sustained dual commit fills the queue at a net +1/cycle.
- stall_req rises on the edge where count_next crosses into BP. It falls on the edge where count_next leaves BP, unless the FSM is in OVF.
- At count == DEPTH with a simultaneous pop: one incoming commit is accepted, and two incoming commits trigger overflow.
- Pointer wrap at DEPTH−1 → 0 is transparent, including a dual write straddling the wrap.
- Reset asserted mid-drain: all outputs return to their reset values immediately; there is no partial output.

## Test plan
- Single commit: cmt_valid_0 = 1, pc 0xBFC00000, wnum 3, wdata 0x12345678, trace_ready = 1 → trace_valid for exactly 1 cycle, 2 edges later, trace_wen 4'hF, fields match.
- Dual commit ordering: slot 0 pc 0x100, slot 1 pc 0x104 in one cycle, ready = 1 → pc 0x100 then 0x104 on consecutive cycles; occupancy peaks at 1.
- Backpressure: trace_ready = 0 with dual commits every cycle → stall_req = 1 after count reaches 12 (DEPTH 16, THRESH 4). The bench honours the stall, and no overflow occurs. Releasing ready drains all entries in order with stall_req falling at count ≤ 11.
- Forced overflow: ignore stall_req, keep ready = 0 → overflow = 1 and state OVF at the first cycle with n_in > free. The queue holds exactly the first 16 entries, drained intact, and stall_req stays 1.
- Flush mid-stream: queue holding 7 entries and output valid, flush = 1 with a dual commit → next cycle trace_valid = 0, occupancy 0, overflow 0, stall_req 0; the flush-cycle commits never appear.
- Wrap and async reset: run 40 mixed single/dual commits with random ready and check the in-order PC sequence across pointer wrap. Then drop reset low mid-stream → outputs at their reset values before the next clk edge.
